// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared op/exception encodings, word types and FSM states for the MEM stage.
package mem_stage_pkg;
    typedef logic [29:0] word_addr_t;
    typedef logic [31:0] word_data_t;
    typedef enum logic [1:0] {
        MEM_OP_NOP = 2'd0,
        MEM_OP_LDW = 2'd1,
        MEM_OP_STW = 2'd2
    } mem_op_e;
    typedef enum logic [1:0] {
        CTRL_OP_NOP  = 2'd0,
        CTRL_OP_WRCR = 2'd1,
        CTRL_OP_EXRT = 2'd2
    } ctrl_op_e;
    typedef enum logic [2:0] {
        ISA_EXP_NO_EXP     = 3'd0,
        ISA_EXP_EXT_INT    = 3'd1,
        ISA_EXP_UNDEF_INSN = 3'd2,
        ISA_EXP_OVERFLOW   = 3'd3,
        ISA_EXP_MISS_ALIGN = 3'd4,
        ISA_EXP_TRAP       = 3'd5,
        ISA_EXP_PRV_VIO    = 3'd6,
        ISA_EXP_BUS_ERR    = 3'd7
    } isa_exp_e;
    localparam logic ENABLE   = 1'b1;
    localparam logic DISABLE  = 1'b0;
    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;
    typedef enum logic {BUS_IDLE, BUS_BUSY} bus_state_e;
endpackage

// File: rtl/mem_stage_if.sv
// mem_stage_if: word-wide req/ready memory bus.
//  req     master->slave  access request, held until rdy
//  rw      master->slave  1 = read, 0 = write
//  addr    master->slave  word address
//  wr_data master->slave  store data
//  rd_data slave->master  load data, valid with rdy
//  rdy     slave->master  access completes this cycle
interface mem_stage_if;
    import mem_stage_pkg::*;
    logic       req;
    logic       rw;
    word_addr_t addr;
    word_data_t wr_data;
    word_data_t rd_data;
    logic       rdy;
    modport master (output req, rw, addr, wr_data, input rd_data, rdy);
    modport slave (input req, rw, addr, wr_data, output rd_data, rdy);
endinterface

// File: rtl/mem_bus_if.sv
// mem_bus_if: bus access FSM with timeout counter and read-data buffer for the MEM stage.
//  clk, rst      clock, async active-low reset
//  start         EX holds a qualifying access
//  stall         pipeline stall (when high the result must be buffered)
//  rdy, bus_rd_data  bus completion and load data
//  req           bus request (forced low while in reset)
//  busy          stall request while the access is outstanding
//  err           access ended by timeout
//  rd_data       load data to the stage register (buffered or live)
module mem_bus_if
    import mem_stage_pkg::*;
#(
    parameter int BUS_TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stall,
    input  logic       rdy,
    input  word_data_t bus_rd_data,
    output logic       req,
    output logic       busy,
    output logic       err,
    output word_data_t rd_data
);
    localparam int CW = BUS_TIMEOUT > 1 ? $clog2(BUS_TIMEOUT) : 1;
    bus_state_e    state, state_nx;
    logic [CW-1:0] cnt;
    logic          tmo, done, req_c, busy_c, buf_vld, buf_err;
    word_data_t    buf_data;
    assign tmo = (BUS_TIMEOUT != 0) && state == BUS_BUSY && cnt == CW'(BUS_TIMEOUT - 1) && !rdy;
    always_comb begin
        state_nx = state;
        req_c    = 1'b0;
        done     = 1'b0;
        busy_c   = 1'b0;
        if (state == BUS_IDLE) begin
            // a buffered result means this EX access already completed
            req_c    = start && !buf_vld;
            done     = req_c && rdy;
            busy_c   = req_c && !rdy;
            state_nx = busy_c ? BUS_BUSY : BUS_IDLE;
        end else begin
            req_c    = !tmo;
            done     = rdy || tmo;
            busy_c   = !done;
            state_nx = done ? BUS_IDLE : BUS_BUSY;
        end
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= BUS_IDLE;
            cnt      <= '0;
            buf_vld  <= 1'b0;
            buf_err  <= 1'b0;
            buf_data <= '0;
        end else begin
            state <= state_nx;
            cnt   <= (state == BUS_BUSY && !done) ? cnt + 1'b1 : '0;
            if (done && stall) begin
                buf_vld  <= 1'b1;
                buf_err  <= tmo;
                buf_data <= bus_rd_data;
            end else if (!stall) begin
                buf_vld <= 1'b0;
            end
        end
    end
    // reset gating makes req/busy drop asynchronously mid-access
    assign req     = req_c && rst;
    assign busy    = busy_c && rst;
    assign err     = buf_vld ? buf_err : tmo;
    assign rd_data = buf_vld ? buf_data : bus_rd_data;
endmodule

// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage; word load/store over a req/ready bus, MEM->WB register.
//  clk, rst          clock, async active-low reset
//  pl_stall/pl_flush pipeline control from the controller
//  ex_*              EX register bundle
//  bus               memory bus (master side)
//  mem_busy          stall request while an access is outstanding
//  mem_*             registered MEM->WB bundle, mem_out = load data or ALU result
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int BUS_TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pl_stall,
    input  logic              pl_flush,
    input  word_addr_t        ex_pc,
    input  logic              ex_en,
    input  logic              ex_br_flag,
    input  logic [2:0]        ex_exp_code,
    input  logic [1:0]        ex_mem_op,
    input  word_data_t        ex_mem_wr_data,
    input  logic [1:0]        ex_ctrl_op,
    input  logic [4:0]        ex_dst_addr,
    input  logic              ex_gpr_we_,
    input  word_data_t        ex_data_out,
    mem_stage_if.master       bus,
    output logic              mem_busy,
    output word_addr_t        mem_pc,
    output logic              mem_en,
    output logic              mem_br_flag,
    output logic [1:0]        mem_ctrl_op,
    output logic [4:0]        mem_dst_addr,
    output logic              mem_gpr_we_,
    output logic [2:0]        mem_exp_code,
    output word_data_t        mem_out
);
    logic       access, misalign, start, err, flush, flush_pend;
    word_data_t rd_data;
    assign access   = ex_en && ex_mem_op != MEM_OP_NOP;
    assign misalign = ex_data_out[1:0] != 2'b00;
    assign start    = access && ex_exp_code == ISA_EXP_NO_EXP && !misalign && !pl_flush;
    // a flush seen while stalled must still clear the bundle once the stall lifts
    assign flush    = pl_flush || flush_pend;
    assign bus.rw      = ex_mem_op == MEM_OP_LDW;
    assign bus.addr    = ex_data_out[31:2];
    assign bus.wr_data = ex_mem_wr_data;
    mem_bus_if #(.BUS_TIMEOUT(BUS_TIMEOUT)) u_bus (
        .clk(clk),
        .rst(rst),
        .start(start),
        .stall(pl_stall),
        .rdy(bus.rdy),
        .bus_rd_data(bus.rd_data),
        .req(bus.req),
        .busy(mem_busy),
        .err(err),
        .rd_data(rd_data)
    );
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flush_pend   <= 1'b0;
            mem_pc       <= '0;
            mem_en       <= DISABLE;
            mem_br_flag  <= 1'b0;
            mem_ctrl_op  <= CTRL_OP_NOP;
            mem_dst_addr <= '0;
            mem_gpr_we_  <= DISABLE_;
            mem_exp_code <= ISA_EXP_NO_EXP;
            mem_out      <= '0;
        end else begin
            flush_pend <= pl_stall && flush;
            if (!pl_stall) begin
                if (flush) begin
                    mem_pc       <= '0;
                    mem_en       <= DISABLE;
                    mem_br_flag  <= 1'b0;
                    mem_ctrl_op  <= CTRL_OP_NOP;
                    mem_dst_addr <= '0;
                    mem_gpr_we_  <= DISABLE_;
                    mem_exp_code <= ISA_EXP_NO_EXP;
                    mem_out      <= '0;
                end else begin
                    mem_pc       <= ex_pc;
                    mem_en       <= ex_en;
                    mem_br_flag  <= ex_br_flag;
                    mem_dst_addr <= ex_dst_addr;
                    if (ex_exp_code != ISA_EXP_NO_EXP || (access && (misalign || err))) begin
                        mem_ctrl_op  <= CTRL_OP_NOP;
                        mem_gpr_we_  <= DISABLE_;
                        mem_out      <= '0;
                        mem_exp_code <= ex_exp_code != ISA_EXP_NO_EXP ? ex_exp_code :
                                        misalign ? ISA_EXP_MISS_ALIGN : ISA_EXP_BUS_ERR;
                    end else begin
                        mem_ctrl_op  <= ex_ctrl_op;
                        mem_gpr_we_  <= ex_gpr_we_;
                        mem_exp_code <= ISA_EXP_NO_EXP;
                        mem_out      <= ex_mem_op == MEM_OP_LDW ? rd_data : ex_data_out;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: table-driven scoreboard bench for mem_stage.
module tb_mem_stage;
    import mem_stage_pkg::*;
    localparam int TMO = 8;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ext_stall = 1'b0;
    logic        pl_flush = 1'b0;
    logic        pl_stall;
    word_addr_t  ex_pc;
    logic        ex_en, ex_br_flag, ex_gpr_we_;
    logic [2:0]  ex_exp_code;
    logic [1:0]  ex_mem_op, ex_ctrl_op;
    logic [4:0]  ex_dst_addr;
    word_data_t  ex_mem_wr_data, ex_data_out;
    logic        mem_busy, mem_en, mem_br_flag, mem_gpr_we_;
    word_addr_t  mem_pc;
    logic [1:0]  mem_ctrl_op;
    logic [4:0]  mem_dst_addr;
    logic [2:0]  mem_exp_code;
    word_data_t  mem_out;
    mem_stage_if bus();
    assign pl_stall = mem_busy | ext_stall;
    always #5 clk = ~clk;
    mem_stage #(.BUS_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .pl_stall(pl_stall), .pl_flush(pl_flush),
        .ex_pc(ex_pc), .ex_en(ex_en), .ex_br_flag(ex_br_flag), .ex_exp_code(ex_exp_code),
        .ex_mem_op(ex_mem_op), .ex_mem_wr_data(ex_mem_wr_data), .ex_ctrl_op(ex_ctrl_op),
        .ex_dst_addr(ex_dst_addr), .ex_gpr_we_(ex_gpr_we_), .ex_data_out(ex_data_out),
        .bus(bus), .mem_busy(mem_busy), .mem_pc(mem_pc), .mem_en(mem_en),
        .mem_br_flag(mem_br_flag), .mem_ctrl_op(mem_ctrl_op), .mem_dst_addr(mem_dst_addr),
        .mem_gpr_we_(mem_gpr_we_), .mem_exp_code(mem_exp_code), .mem_out(mem_out)
    );
    typedef struct {
        logic [1:0]  op;
        logic [31:0] addr, wdata, rdata;
        int          lat, xs, fl;
        logic [2:0]  exp_in;
        logic        en;
        logic [31:0] e_out;
        logic [2:0]  e_exp;
        logic        e_we, e_en;
        int          e_busy;
        logic        e_req;
    } vec_t;
    typedef struct {
        logic [31:0] out, pc, addr, wdata;
        logic [2:0]  exp;
        logic [1:0]  ctrl;
        logic [4:0]  dst;
        logic        we, en, br, req, rw, normal;
        int          busy;
    } exp_t;
    vec_t vecs[14];
    exp_t sb[$];
    int checks = 0;
    int passes = 0;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act === want) passes++;
        else $display("FAIL %s: got %h expected %h", nm, act, want);
    endtask
    task automatic run_vec(input vec_t v, input int idx);
        exp_t e;
        int waited, busy_n;
        logic saw_req, done, rq, rw;
        logic [29:0] a;
        logic [31:0] wd;
        @(negedge clk);
        ex_pc = 30'(idx * 4 + 16);
        ex_en = v.en;
        ex_br_flag = 1'b1;
        ex_exp_code = v.exp_in;
        ex_mem_op = v.op;
        ex_mem_wr_data = v.wdata;
        ex_ctrl_op = 2'd1;
        ex_dst_addr = 5'(idx + 1);
        ex_gpr_we_ = v.op == MEM_OP_STW;
        ex_data_out = v.addr;
        e.out = v.e_out;
        e.exp = v.e_exp;
        e.we = v.e_we;
        e.en = v.e_en;
        e.busy = v.e_busy;
        e.req = v.e_req;
        e.pc = v.fl >= 0 ? 32'd0 : 32'(ex_pc);
        e.br = v.fl < 0;
        e.normal = v.fl < 0 && v.e_exp == ISA_EXP_NO_EXP;
        e.ctrl = e.normal ? 2'd1 : 2'd0;
        e.dst = ex_dst_addr;
        e.addr = {2'b00, v.addr[31:2]};
        e.rw = v.op == MEM_OP_LDW;
        e.wdata = v.wdata;
        sb.push_back(e);
        waited = 0; busy_n = 0; saw_req = 0; done = 0; a = '0; rw = 0; wd = '0;
        for (int c = 0; c < 64 && !done; c++) begin
            ext_stall = c < v.xs;
            pl_flush = c == v.fl;
            #1;
            bus.rdy = bus.req && v.lat >= 0 && waited >= v.lat;
            bus.rd_data = bus.rdy ? v.rdata : 32'hBAD0_BAD0;
            #1;
            rq = bus.req;
            if (rq && !saw_req) begin
                saw_req = 1; a = bus.addr; rw = bus.rw; wd = bus.wr_data;
            end
            if (mem_busy) busy_n++;
            done = !pl_stall;
            @(posedge clk);
            #1;
            if (rq) waited++;
            bus.rdy = 1'b0;
            pl_flush = 1'b0;
            if (!done) @(negedge clk);
        end
        chk($sformatf("v%0d_captured", idx), 32'(done), 32'd1);
        e = sb.pop_front();
        chk($sformatf("v%0d_out", idx), mem_out, e.out);
        chk($sformatf("v%0d_exp", idx), 32'(mem_exp_code), 32'(e.exp));
        chk($sformatf("v%0d_gpr_we_", idx), 32'(mem_gpr_we_), 32'(e.we));
        chk($sformatf("v%0d_en", idx), 32'(mem_en), 32'(e.en));
        chk($sformatf("v%0d_pc", idx), 32'(mem_pc), e.pc);
        chk($sformatf("v%0d_br", idx), 32'(mem_br_flag), 32'(e.br));
        chk($sformatf("v%0d_ctrl", idx), 32'(mem_ctrl_op), 32'(e.ctrl));
        chk($sformatf("v%0d_busy_cycles", idx), 32'(busy_n), 32'(e.busy));
        chk($sformatf("v%0d_req_seen", idx), 32'(saw_req), 32'(e.req));
        if (e.normal) chk($sformatf("v%0d_dst", idx), 32'(mem_dst_addr), 32'(e.dst));
        if (e.req) begin
            chk($sformatf("v%0d_bus_addr", idx), 32'(a), e.addr);
            chk($sformatf("v%0d_bus_rw", idx), 32'(rw), 32'(e.rw));
            if (!e.rw) chk($sformatf("v%0d_bus_wr_data", idx), wd, e.wdata);
        end
        ex_en = 1'b0;
        ext_stall = 1'b0;
        #1;
        chk($sformatf("v%0d_req_idle_after", idx), 32'(bus.req), 32'd0);
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
    initial begin
        ex_pc = '0; ex_en = 0; ex_br_flag = 0; ex_exp_code = 0; ex_mem_op = 0;
        ex_mem_wr_data = '0; ex_ctrl_op = 0; ex_dst_addr = 0; ex_gpr_we_ = 0; ex_data_out = '0;
        bus.rdy = 0; bus.rd_data = '0;
        //          op          addr          wdata         rdata         lat xs fl exp_in             en  e_out         e_exp               we en busy req
        vecs[0]  = '{MEM_OP_LDW, 32'h100, 32'h0,        32'hDEADBEEF, 3,  0, -1, ISA_EXP_NO_EXP,     1, 32'hDEADBEEF, ISA_EXP_NO_EXP,     0, 1, 3, 1};
        vecs[1]  = '{MEM_OP_STW, 32'h104, 32'h12345678, 32'h0,        0,  0, -1, ISA_EXP_NO_EXP,     1, 32'h104,      ISA_EXP_NO_EXP,     1, 1, 0, 1};
        vecs[2]  = '{MEM_OP_LDW, 32'h102, 32'h0,        32'h0,        1,  0, -1, ISA_EXP_NO_EXP,     1, 32'h0,        ISA_EXP_MISS_ALIGN, 1, 1, 0, 0};
        vecs[3]  = '{MEM_OP_LDW, 32'h200, 32'h0,        32'h0,        -1, 0, -1, ISA_EXP_NO_EXP,     1, 32'h0,        ISA_EXP_BUS_ERR,    1, 1, TMO, 1};
        vecs[4]  = '{MEM_OP_LDW, 32'h300, 32'h0,        32'hCAFEF00D, 3,  0, 1,  ISA_EXP_NO_EXP,     1, 32'h0,        ISA_EXP_NO_EXP,     1, 0, 3, 1};
        vecs[5]  = '{MEM_OP_LDW, 32'h400, 32'h0,        32'hA5A5A5A5, 2,  5, -1, ISA_EXP_NO_EXP,     1, 32'hA5A5A5A5, ISA_EXP_NO_EXP,     0, 1, 2, 1};
        vecs[6]  = '{MEM_OP_LDW, 32'h500, 32'h0,        32'h0,        1,  0, -1, ISA_EXP_OVERFLOW,   1, 32'h0,        ISA_EXP_OVERFLOW,   1, 1, 0, 0};
        vecs[7]  = '{MEM_OP_LDW, 32'h503, 32'h0,        32'h0,        1,  0, -1, ISA_EXP_UNDEF_INSN, 1, 32'h0,        ISA_EXP_UNDEF_INSN, 1, 1, 0, 0};
        vecs[8]  = '{MEM_OP_NOP, 32'h777, 32'h0,        32'h0,        0,  0, -1, ISA_EXP_NO_EXP,     1, 32'h777,      ISA_EXP_NO_EXP,     0, 1, 0, 0};
        vecs[9]  = '{MEM_OP_STW, 32'h105, 32'h55,       32'h0,        1,  0, -1, ISA_EXP_NO_EXP,     1, 32'h0,        ISA_EXP_MISS_ALIGN, 1, 1, 0, 0};
        vecs[10] = '{MEM_OP_LDW, 32'h600, 32'h0,        32'h1111,     0,  0, -1, ISA_EXP_NO_EXP,     1, 32'h1111,     ISA_EXP_NO_EXP,     0, 1, 0, 1};
        vecs[11] = '{MEM_OP_NOP, 32'h700, 32'h0,        32'h0,        0,  0, -1, ISA_EXP_NO_EXP,     0, 32'h700,      ISA_EXP_NO_EXP,     0, 0, 0, 0};
        vecs[12] = '{MEM_OP_LDW, 32'h900, 32'h0,        32'h0,        0,  0, 0,  ISA_EXP_NO_EXP,     1, 32'h0,        ISA_EXP_NO_EXP,     1, 0, 0, 0};
        vecs[13] = '{MEM_OP_LDW, 32'h20,  32'h0,        32'h0BADCAFE, 0,  2, -1, ISA_EXP_NO_EXP,     1, 32'h0BADCAFE, ISA_EXP_NO_EXP,     0, 1, 0, 1};
        @(posedge clk);
        #1;
        chk("rst_en", 32'(mem_en), 32'd0);
        chk("rst_gpr_we_", 32'(mem_gpr_we_), 32'd1);
        chk("rst_exp", 32'(mem_exp_code), 32'd0);
        chk("rst_ctrl", 32'(mem_ctrl_op), 32'd0);
        chk("rst_out", mem_out, 32'd0);
        chk("rst_req", 32'(bus.req), 32'd0);
        chk("rst_busy", 32'(mem_busy), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 14; i++) run_vec(vecs[i], i);
        @(negedge clk);
        ex_en = 1; ex_mem_op = MEM_OP_LDW; ex_exp_code = 0; ex_data_out = 32'h800;
        ex_gpr_we_ = 0; ex_pc = 30'h123;
        repeat (2) @(negedge clk);
        #1;
        chk("midrst_pre_req", 32'(bus.req), 32'd1);
        chk("midrst_pre_busy", 32'(mem_busy), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("midrst_req", 32'(bus.req), 32'd0);
        chk("midrst_busy", 32'(mem_busy), 32'd0);
        chk("midrst_en", 32'(mem_en), 32'd0);
        chk("midrst_gpr_we_", 32'(mem_gpr_we_), 32'd1);
        chk("midrst_out", mem_out, 32'd0);
        chk("midrst_pc", 32'(mem_pc), 32'd0);
        ex_en = 0;
        @(negedge clk);
        rst = 1'b1;
        run_vec(vecs[0], 14);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
